dual_issue_launch_ctrl: RTL and testbench

Launch controller between the IF/ID instruction queue and the ID/EXE pipeline register. It inspects the two instructions at the queue tail and decides whether to launch two, one or zero of them this cycle. It returns that decision to the queue as one-hot launch flags and registers the launched pair into a one-entry output stage. It also enforces pair hazard rules and the serialisation of CSR/barrier-class instructions.

---
 rtl/dual_issue_launch_ctrl_pkg.sv | 27 ++
 rtl/dual_issue_launch_ctrl_pair_hazard_check.sv | 39 +++
 rtl/dual_issue_launch_ctrl.sv | 114 +++++++++++
 tb/tb_dual_issue_launch_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dual_issue_launch_ctrl_pkg.sv
// Shared constants for the dual-issue launch controller: line widths,
// decode-info field offsets and the serialisation FSM state encodings.
package dual_issue_launch_ctrl_pkg;

  localparam int LINE_W        = 128;
  localparam int INFO_W        = 22;
  localparam int DOUBLE_LAUNCH = 1;

  // info = {is_serial, is_md, is_mem, is_br, rk_re, rk, rj_re, rj, rd_we, rd}
  localparam int RD_LSB        = 0;
  localparam int RD_WE_BIT     = 5;
  localparam int RJ_LSB        = 6;
  localparam int RJ_RE_BIT     = 11;
  localparam int RK_LSB        = 12;
  localparam int RK_RE_BIT     = 17;
  localparam int IS_BR_BIT     = 18;
  localparam int IS_MEM_BIT    = 19;
  localparam int IS_MD_BIT     = 20;
  localparam int IS_SERIAL_BIT = 21;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HOLD   = 2'd2
  } launch_state_e;

endpackage

// File: rtl/dual_issue_launch_ctrl_pair_hazard_check.sv
// Decides whether line2 may launch in the same cycle as line1, looking only
// at the decode info of the two lines.
module pair_hazard_check
  import dual_issue_launch_ctrl_pkg::*;
(
  input  logic [INFO_W-1:0] line1_info,
  input  logic [INFO_W-1:0] line2_info,
  output logic              pair_legal
);

  logic [4:0] rd1;
  logic [4:0] rd2;
  logic [4:0] rj2;
  logic [4:0] rk2;
  logic       raw;
  logic       waw;
  logic       res_conflict;
  logic       unused_fields;

  // Source fields of line1 and the branch flag of line2 play no part in pairing.
  assign unused_fields = ^{line1_info[RK_RE_BIT:RJ_LSB], line2_info[IS_BR_BIT]};

  always_comb begin
    rd1 = line1_info[RD_LSB +: 5];
    rd2 = line2_info[RD_LSB +: 5];
    rj2 = line2_info[RJ_LSB +: 5];
    rk2 = line2_info[RK_LSB +: 5];
    raw = line1_info[RD_WE_BIT] && (rd1 != 5'd0) &&
          ((line2_info[RJ_RE_BIT] && (rj2 == rd1)) ||
           (line2_info[RK_RE_BIT] && (rk2 == rd1)));
    waw = line1_info[RD_WE_BIT] && line2_info[RD_WE_BIT] &&
          (rd1 != 5'd0) && (rd1 == rd2);
    res_conflict = (line1_info[IS_MEM_BIT] && line2_info[IS_MEM_BIT]) ||
                   (line1_info[IS_MD_BIT] && line2_info[IS_MD_BIT]);
    pair_legal = !raw && !waw && !res_conflict && !line1_info[IS_BR_BIT] &&
                 !line1_info[IS_SERIAL_BIT] && !line2_info[IS_SERIAL_BIT];
  end

endmodule

// File: rtl/dual_issue_launch_ctrl.sv
// Launch controller between the IF/ID queue and ID/EXE: picks two, one or zero
// instructions per cycle and registers the launched pair into a one-entry stage.
module dual_issue_launch_ctrl
  import dual_issue_launch_ctrl_pkg::*;
#(
  parameter int LINE_W        = dual_issue_launch_ctrl_pkg::LINE_W,
  parameter int INFO_W        = dual_issue_launch_ctrl_pkg::INFO_W,
  parameter int DOUBLE_LAUNCH = dual_issue_launch_ctrl_pkg::DOUBLE_LAUNCH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                branch_flush_i,
  input  logic                excep_flush_i,
  input  logic                line1_valid_i,
  input  logic                line2_valid_i,
  input  logic [INFO_W-1:0]   line1_info_i,
  input  logic [INFO_W-1:0]   line2_info_i,
  input  logic [2*LINE_W-1:0] from_queue_ibus,
  input  logic                next_allowin_i,
  input  logic                pipe_empty_i,
  input  logic                serial_done_i,
  output logic                double_valid_inst_lunch_flag_o,
  output logic                single_valid_inst_lunch_flag_o,
  output logic                zero_valid_inst_lunch_flag_o,
  output logic                line1_valid_o,
  output logic                line2_valid_o,
  output logic [2*LINE_W-1:0] to_next_obus,
  output logic                error_o
);

  launch_state_e state;
  logic flush;
  logic out_ready;
  logic line_err;
  logic l1_serial;
  logic can_launch;
  logic pair_legal;
  logic double_ok;
  logic launch_double;
  logic launch_single;

  pair_hazard_check u_pair_hazard_check (
    .line1_info (line1_info_i),
    .line2_info (line2_info_i),
    .pair_legal (pair_legal)
  );

  // Launch decision; consumed by the queue at the same edge.
  always_comb begin
    flush         = !rst_n || branch_flush_i || excep_flush_i;
    out_ready     = !line1_valid_o || next_allowin_i;
    line_err      = line2_valid_i && !line1_valid_i;
    l1_serial     = line1_info_i[IS_SERIAL_BIT];
    can_launch    = !flush && out_ready && line1_valid_i && !line_err;
    double_ok     = (DOUBLE_LAUNCH != 0) && line2_valid_i && pair_legal;
    launch_double = 1'b0;
    launch_single = 1'b0;
    case (state)
      ST_NORMAL: begin
        if (can_launch && !l1_serial) begin
          if (double_ok) begin
            launch_double = 1'b1;
          end else begin
            launch_single = 1'b1;
          end
        end else begin
          launch_single = 1'b0;
        end
      end
      // The serial instruction leaves alone once everything ahead has drained.
      ST_DRAIN: begin
        if (can_launch && pipe_empty_i && !line1_valid_o) begin
          launch_single = 1'b1;
        end else begin
          launch_single = 1'b0;
        end
      end
      default: begin
        launch_single = 1'b0;
      end
    endcase
  end

  assign double_valid_inst_lunch_flag_o = launch_double;
  assign single_valid_inst_lunch_flag_o = launch_single;
  assign zero_valid_inst_lunch_flag_o   = !(launch_double || launch_single);
  assign error_o                        = rst_n && line_err;

  // Serialisation FSM and the one-entry output stage.
  always_ff @(posedge clk) begin
    if (flush) begin
      state         <= ST_NORMAL;
      line1_valid_o <= 1'b0;
      line2_valid_o <= 1'b0;
      to_next_obus  <= '0;
    end else begin
      case (state)
        ST_NORMAL: if (line1_valid_i && l1_serial) state <= ST_DRAIN;
        ST_DRAIN:  if (launch_single) state <= ST_HOLD;
        ST_HOLD:   if (serial_done_i) state <= ST_NORMAL;
        default:   state <= ST_NORMAL;
      endcase
      if (launch_double || launch_single) begin
        to_next_obus  <= from_queue_ibus;
        line1_valid_o <= 1'b1;
        line2_valid_o <= launch_double;
      end else if (next_allowin_i) begin
        line1_valid_o <= 1'b0;
        line2_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dual_issue_launch_ctrl.sv
// Directed bench for dual_issue_launch_ctrl: a rule-level model is checked every
// cycle, and hand-computed literals pin key scenarios.
module tb_dual_issue_launch_ctrl;
  import dual_issue_launch_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n, bf, ef, l1v, l2v, nal, pe, sd;
  logic [21:0]  i1, i2;
  logic [255:0] ibus;
  logic dbl, sgl, zro, o1v, o2v, err;
  logic [255:0] obus;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  // Model state: what the output stage holds and where the serial handshake is.
  logic m_v1, m_v2, m_wait_empty, m_wait_done;
  logic [255:0] m_bus;

  always #5 clk = ~clk;

  dual_issue_launch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .branch_flush_i(bf), .excep_flush_i(ef),
    .line1_valid_i(l1v), .line2_valid_i(l2v),
    .line1_info_i(i1), .line2_info_i(i2), .from_queue_ibus(ibus),
    .next_allowin_i(nal), .pipe_empty_i(pe), .serial_done_i(sd),
    .double_valid_inst_lunch_flag_o(dbl), .single_valid_inst_lunch_flag_o(sgl),
    .zero_valid_inst_lunch_flag_o(zro),
    .line1_valid_o(o1v), .line2_valid_o(o2v), .to_next_obus(obus), .error_o(err)
  );

  function automatic logic [21:0] mk(bit ser, bit md, bit mem, bit br, bit rkre, int rk,
                                     bit rjre, int rj, bit we, int rd);
    return {ser, md, mem, br, rkre, 5'(rk), rjre, 5'(rj), we, 5'(rd)};
  endfunction

  function automatic bit legal(logic [21:0] a, logic [21:0] b);
    int ard = int'(a[4:0]);
    int brd = int'(b[4:0]);
    int brj = int'(b[10:6]);
    int brk = int'(b[16:12]);
    if (a[5] && ard != 0 && ((b[11] && brj == ard) || (b[17] && brk == ard))) return 1'b0;
    if (a[5] && b[5] && ard != 0 && ard == brd) return 1'b0;
    if ((a[19] && b[19]) || (a[20] && b[20])) return 1'b0;
    if (a[18] || a[21] || b[21]) return 1'b0;
    return 1'b1;
  endfunction

  // Number of instructions that must launch given current inputs and model state.
  function automatic int decide();
    if (!rst_n || bf || ef) return 0;
    if (!l1v) return 0;
    if (m_v1 && !nal) return 0;
    if (m_wait_done) return 0;
    if (m_wait_empty) return (pe && !m_v1) ? 1 : 0;
    if (i1[21]) return 0;
    return (DOUBLE_LAUNCH != 0 && l2v && legal(i1, i2)) ? 2 : 1;
  endfunction

  task automatic cmp(string nm, logic [255:0] act, logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model update at the launch edge.
  always @(posedge clk) begin
    int n;
    n = decide();
    if (!rst_n || bf || ef) begin
      m_v1 <= 1'b0; m_v2 <= 1'b0; m_bus <= '0;
      m_wait_empty <= 1'b0; m_wait_done <= 1'b0;
    end else begin
      if (!m_wait_empty && !m_wait_done && l1v && i1[21]) m_wait_empty <= 1'b1;
      if (m_wait_empty && n == 1) begin
        m_wait_empty <= 1'b0;
        m_wait_done  <= 1'b1;
      end
      if (m_wait_done && sd) m_wait_done <= 1'b0;
      if (n > 0) begin
        m_v1 <= 1'b1; m_v2 <= (n == 2); m_bus <= ibus;
      end else if (nal) begin
        m_v1 <= 1'b0; m_v2 <= 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int n;
    if (chk_on) begin
      n = decide();
      cmp("m_double", 256'(dbl), 256'(n == 2));
      cmp("m_single", 256'(sgl), 256'(n == 1));
      cmp("m_zero",   256'(zro), 256'(n == 0));
      cmp("m_error",  256'(err), 256'(rst_n && l2v && !l1v));
      cmp("m_v1",     256'(o1v), 256'(m_v1));
      cmp("m_v2",     256'(o2v), 256'(m_v2));
      cmp("m_bus1",   256'(obus[127:0]), 256'(m_bus[127:0]));
      if (m_v2) cmp("m_bus2", 256'(obus[255:128]), 256'(m_bus[255:128]));
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v1, logic v2, logic [21:0] a, logic [21:0] b, logic [255:0] p);
    l1v = v1; l2v = v2; i1 = a; i2 = b; ibus = p;
  endtask

  logic [255:0] pay1, pay2, pay3, pay4, pay5, pay6;
  logic [21:0] ind1, ind2;

  initial begin
    pay1 = {{4{32'hB1B1_0001}}, {4{32'hA1A1_0001}}};
    pay2 = {{4{32'hB2B2_0002}}, {4{32'hA2A2_0002}}};
    pay3 = {{4{32'hB3B3_0003}}, {4{32'hA3A3_0003}}};
    pay4 = {{4{32'hB4B4_0004}}, {4{32'hA4A4_0004}}};
    pay5 = {{4{32'hB5B5_0005}}, {4{32'hA5A5_0005}}};
    pay6 = {{4{32'hB6B6_0006}}, {4{32'hA6A6_0006}}};
    ind1 = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 4);
    ind2 = mk(0, 0, 0, 0, 0, 0, 1, 5, 1, 6);
    rst_n = 1'b0; bf = 1'b0; ef = 1'b0; nal = 1'b1; pe = 1'b1; sd = 1'b0;
    drive(0, 0, 22'd0, 22'd0, 256'd0);
    nxt(); chk_on = 1'b1;
    @(negedge clk); cmp("rst_zero", 256'(zro), 256'd1);
    nxt(); rst_n = 1'b1;
    @(negedge clk);
    cmp("post_rst_zero", 256'(zro), 256'd1);
    cmp("post_rst_v1", 256'(o1v), 256'd0);
    cmp("post_rst_bus", obus, 256'd0);

    // Independent pair.
    nxt(); drive(1, 1, ind1, ind2, pay1);
    @(negedge clk); cmp("indep_double", 256'(dbl), 256'd1);
    nxt(); drive(0, 0, 22'd0, 22'd0, 256'd0);
    @(negedge clk);
    cmp("indep_v1", 256'(o1v), 256'd1);
    cmp("indep_v2", 256'(o2v), 256'd1);
    cmp("indep_bus", obus, pay1);

    // RAW through rk, then the same shape on r0.
    nxt(); drive(1, 1, ind1, mk(0, 0, 0, 0, 1, 4, 0, 0, 0, 0), pay2);
    @(negedge clk); cmp("raw_single", 256'(sgl), 256'd1);
    nxt(); drive(0, 0, 22'd0, 22'd0, 256'd0);
    @(negedge clk); cmp("raw_v2", 256'(o2v), 256'd0); cmp("raw_v1", 256'(o1v), 256'd1);
    nxt(); drive(1, 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0), pay3);
    @(negedge clk); cmp("r0_double", 256'(dbl), 256'd1);

    // Backpressure for three cycles, then release.
    for (int k = 0; k < 3; k++) begin
      nxt(); nal = 1'b0; drive(1, 1, ind1, ind2, pay4);
      @(negedge clk); cmp("bp_zero", 256'(zro), 256'd1); cmp("bp_bus", obus, pay3);
    end
    nxt(); nal = 1'b1;
    @(negedge clk); cmp("bp_resume_double", 256'(dbl), 256'd1);

    // Serial instruction: drain, launch alone, hold until retired.
    for (int k = 0; k < 4; k++) begin
      nxt(); pe = 1'b0; drive(1, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 22'd0, pay5);
      @(negedge clk); cmp("drain_zero", 256'(zro), 256'd1);
    end
    nxt(); pe = 1'b1;
    @(negedge clk); cmp("drain_exit_single", 256'(sgl), 256'd1);
    for (int k = 0; k < 2; k++) begin
      nxt(); drive(1, 1, ind1, ind2, pay6);
      @(negedge clk); cmp("hold_zero", 256'(zro), 256'd1);
    end
    nxt(); sd = 1'b1;
    @(negedge clk); cmp("done_cycle_zero", 256'(zro), 256'd1);
    nxt(); sd = 1'b0;
    @(negedge clk); cmp("after_done_double", 256'(dbl), 256'd1);

    // Flush while holding a valid output.
    nxt(); drive(1, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 22'd0, pay5);
    @(negedge clk); cmp("ser2_zero", 256'(zro), 256'd1);
    nxt();
    @(negedge clk); cmp("ser2_single", 256'(sgl), 256'd1);
    nxt(); nal = 1'b0; drive(1, 1, ind1, ind2, pay2);
    @(negedge clk); cmp("hold2_zero", 256'(zro), 256'd1); cmp("hold2_v1", 256'(o1v), 256'd1);
    nxt(); bf = 1'b1; sd = 1'b1;
    @(negedge clk); cmp("flush_zero", 256'(zro), 256'd1);
    nxt(); bf = 1'b0; sd = 1'b0; nal = 1'b1;
    @(negedge clk);
    cmp("flush_v1", 256'(o1v), 256'd0);
    cmp("flush_v2", 256'(o2v), 256'd0);
    cmp("flush_then_double", 256'(dbl), 256'd1);

    // Protocol error with the output stage stalled.
    nxt(); nal = 1'b0; drive(0, 1, ind1, ind2, pay6);
    @(negedge clk); cmp("err_flag", 256'(err), 256'd1); cmp("err_zero", 256'(zro), 256'd1);
    nxt();
    @(negedge clk); cmp("err_hold_bus", obus, pay2); cmp("err_hold_v1", 256'(o1v), 256'd1);

    // Further pair rules, each forcing a single launch.
    nxt(); nal = 1'b1; drive(1, 1, mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0), ind2, pay1);
    @(negedge clk); cmp("br_single", 256'(sgl), 256'd1);
    nxt(); drive(1, 1, mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0), mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0), pay3);
    @(negedge clk); cmp("mem_single", 256'(sgl), 256'd1);
    nxt(); drive(1, 1, mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), pay4);
    @(negedge clk); cmp("md_single", 256'(sgl), 256'd1);
    nxt(); drive(1, 1, ind1, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 4), pay5);
    @(negedge clk); cmp("waw_single", 256'(sgl), 256'd1);
    nxt(); drive(1, 1, ind1, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), pay6);
    @(negedge clk); cmp("l2_serial_single", 256'(sgl), 256'd1);
    nxt(); drive(1, 0, ind1, 22'd0, pay1);
    @(negedge clk); cmp("lone_single", 256'(sgl), 256'd1);

    // Exception flush on a launch cycle.
    nxt(); ef = 1'b1; drive(1, 1, ind1, ind2, pay2);
    @(negedge clk); cmp("exflush_zero", 256'(zro), 256'd1);
    nxt(); ef = 1'b0; drive(0, 0, 22'd0, 22'd0, 256'd0);
    @(negedge clk); cmp("exflush_v1", 256'(o1v), 256'd0); cmp("exflush_bus", obus, 256'd0);

    nxt(); nxt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
